pc_sequencer: RTL and testbench

//  Owns the program counter and sequences instruction fetch for the MIPS core.

---
 rtl/pc_seq_pkg.sv | 20 ++
 rtl/pc_sequencer_if.sv | 11 +
 rtl/mux_4to1.sv | 27 ++
 rtl/pc_sequencer.sv | 97 +++++++++
 tb/tb_pc_sequencer.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: next-PC select codes and FSM states.
package pc_seq_pkg;

  // Next-PC select codes driven on jump_op
  typedef enum logic [1:0] {
    C_ADD4   = 2'b00,
    C_BRANCH = 2'b01,
    C_REG    = 2'b10,
    C_JUMP   = 2'b11
  } jump_op_t;

  // Sequencer states
  typedef enum logic [1:0] {
    BOOT  = 2'b00,
    FETCH = 2'b01,
    EXEC  = 2'b10,
    HALT  = 2'b11
  } state_t;

endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction memory fetch handshake between the PC sequencer and imem.
interface pc_sequencer_if #(
  parameter int unsigned mem_size = 18
);
  logic                imem_req;
  logic                imem_ready;
  logic [mem_size-1:0] imem_addr;

  modport master (output imem_req, output imem_addr, input imem_ready);
  modport slave  (input imem_req, input imem_addr, output imem_ready);
endinterface

// File: rtl/mux_4to1.sv
// Four-way next-PC mux indexed by the jump_op select code.
module mux_4to1
  import pc_seq_pkg::*;
#(
  parameter int unsigned mem_size = 18
) (
  input  jump_op_t            sel,
  input  logic [mem_size-1:0] in_add4,
  input  logic [mem_size-1:0] in_branch,
  input  logic [mem_size-1:0] in_reg,
  input  logic [mem_size-1:0] in_jump,
  output logic [mem_size-1:0] out
);

  // Select the next-PC candidate
  always_comb begin
    out = in_add4;
    unique case (sel)
      C_ADD4:   out = in_add4;
      C_BRANCH: out = in_branch;
      C_REG:    out = in_reg;
      C_JUMP:   out = in_jump;
      default:  out = in_add4;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/execute sequencer for the MIPS core.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned         mem_size = 18,
  parameter logic [mem_size-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  pc_sequencer_if.master      imem,
  output logic                instr_valid,
  input  logic                is_j,
  input  logic                is_jr,
  input  logic                is_branch,
  input  logic                branch_taken,
  input  logic                stall,
  input  logic                halt,
  input  logic [mem_size-1:0] jump_addr,
  input  logic [mem_size-1:0] branch_offset,
  input  logic [mem_size-1:0] reg_addr,
  output logic [1:0]          jump_op,
  output logic [mem_size-1:0] pc,
  output logic                halted,
  output logic                misalign_err
);

  state_t              state, state_nx;
  jump_op_t            sel;
  logic                pc_load;
  logic [mem_size-1:0] pc_plus4;
  logic [mem_size-1:0] next_pc;

  // Sequential fall-through address; wraps naturally at the address width
  assign pc_plus4 = pc + mem_size'(4);

  mux_4to1 #(
    .mem_size (mem_size)
  ) u_mux (
    .sel       (sel),
    .in_add4   (pc_plus4),
    .in_branch (branch_offset),
    .in_reg    (reg_addr),
    .in_jump   (jump_addr),
    .out       (next_pc)
  );

  // Next-PC select priority: J > JR > taken branch > sequential; only in EXEC
  always_comb begin
    sel = C_ADD4;
    if (state == EXEC) begin
      if (is_j)                         sel = C_JUMP;
      else if (is_jr)                   sel = C_REG;
      else if (is_branch && branch_taken) sel = C_BRANCH;
      else                              sel = C_ADD4;
    end
  end

  // FSM next state and PC load strobe
  always_comb begin
    state_nx = state;
    pc_load  = 1'b0;
    unique case (state)
      BOOT:  state_nx = FETCH;
      FETCH: if (imem.imem_ready) state_nx = EXEC;
      EXEC: begin
        if (!stall) begin
          pc_load  = 1'b1;
          state_nx = halt ? HALT : FETCH;
        end
      end
      HALT:    state_nx = HALT;
      default: state_nx = BOOT;
    endcase
  end

  // State, PC and sticky misalignment flag; target low bits are forced to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (pc_load) begin
        pc <= {next_pc[mem_size-1:2], 2'b00};
        if (next_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end
    end
  end

  assign jump_op        = sel;
  assign imem.imem_req  = (state == FETCH);
  assign imem.imem_addr = pc;
  assign instr_valid    = (state == EXEC);
  assign halted         = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: instruction table plus PC scoreboard.
module tb_pc_sequencer;

  localparam int unsigned AW = 18;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic          is_j, is_jr, is_branch, branch_taken, stall, halt;
  logic [AW-1:0] jump_addr, branch_offset, reg_addr;
  logic [1:0]    jump_op;
  logic [AW-1:0] pc;
  logic          halted, misalign_err;

  pc_sequencer_if #(.mem_size(AW)) bus ();

  pc_sequencer #(
    .mem_size (AW),
    .RESET_PC ('0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .instr_valid   (instr_valid),
    .is_j          (is_j),
    .is_jr         (is_jr),
    .is_branch     (is_branch),
    .branch_taken  (branch_taken),
    .stall         (stall),
    .halt          (halt),
    .jump_addr     (jump_addr),
    .branch_offset (branch_offset),
    .reg_addr      (reg_addr),
    .jump_op       (jump_op),
    .pc            (pc),
    .halted        (halted),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          j, jr, br, tk;
    logic [AW-1:0] jaddr, boff, raddr;
    int            wait_n, stall_n;
    logic          hlt;
    logic [1:0]    exp_op;
    logic [AW-1:0] exp_pc;
    logic          exp_err;
  } vec_t;

  typedef struct {
    logic [AW-1:0] pc;
    logic          err;
    logic          halted;
  } exp_t;

  vec_t  vecs[16];
  exp_t  sb[$];
  int    checks = 0;
  int    errors = 0;
  logic [AW-1:0] cur_pc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    is_j = 0; is_jr = 0; is_branch = 0; branch_taken = 0;
    stall = 0; halt = 0; bus.imem_ready = 0;
    jump_addr = '0; branch_offset = '0; reg_addr = '0;
  endtask

  // Runs one instruction starting at a negedge in FETCH
  task automatic do_instr(input vec_t v, input int idx);
    exp_t e, got;
    check($sformatf("v%0d fetch_req", idx), 32'(bus.imem_req), 1);
    check($sformatf("v%0d fetch_addr", idx), 32'(bus.imem_addr), 32'(cur_pc));
    for (int w = 0; w < v.wait_n; w++) begin
      bus.imem_ready = 0;
      halt = 1;                       // must be ignored outside EXEC
      @(negedge clk);
      check($sformatf("v%0d wait_req", idx), 32'(bus.imem_req), 1);
      check($sformatf("v%0d wait_pc", idx), 32'(pc), 32'(cur_pc));
    end
    halt = 0;
    bus.imem_ready = 1;
    @(negedge clk);
    is_j = v.j; is_jr = v.jr; is_branch = v.br; branch_taken = v.tk;
    jump_addr = v.jaddr; branch_offset = v.boff; reg_addr = v.raddr;
    stall = (v.stall_n > 0);
    halt = v.hlt;
    bus.imem_ready = 1;               // must be ignored in EXEC
    #1;
    check($sformatf("v%0d instr_valid", idx), 32'(instr_valid), 1);
    check($sformatf("v%0d exec_req", idx), 32'(bus.imem_req), 0);
    check($sformatf("v%0d jump_op", idx), 32'(jump_op), 32'(v.exp_op));
    for (int s = 0; s < v.stall_n; s++) begin
      @(negedge clk);
      check($sformatf("v%0d stall_valid", idx), 32'(instr_valid), 1);
      check($sformatf("v%0d stall_pc", idx), 32'(pc), 32'(cur_pc));
      check($sformatf("v%0d stall_halted", idx), 32'(halted), 0);
      if (s == v.stall_n - 1) stall = 0;
    end
    e.pc = v.exp_pc; e.err = v.exp_err; e.halted = v.hlt;
    sb.push_back(e);
    @(negedge clk);
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL v%0d scoreboard: got empty expected entry", idx);
    end else begin
      got = sb.pop_front();
      check($sformatf("v%0d pc", idx), 32'(pc), 32'(got.pc));
      check($sformatf("v%0d err", idx), 32'(misalign_err), 32'(got.err));
      check($sformatf("v%0d halted", idx), 32'(halted), 32'(got.halted));
      check($sformatf("v%0d next_req", idx), 32'(bus.imem_req), 32'(!got.halted));
    end
    clear_inputs();
    cur_pc = v.exp_pc;
  endtask

  initial begin
    int n;
    //          j  jr br tk  jaddr       boff        raddr      wt st h  op     exp_pc      err
    vecs[0]  = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     0, 0, 0, 2'b00, 18'h4,      0};
    vecs[1]  = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     0, 0, 0, 2'b00, 18'h8,      0};
    vecs[2]  = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     0, 0, 0, 2'b00, 18'hC,      0};
    vecs[3]  = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     0, 0, 0, 2'b00, 18'h10,     0};
    vecs[4]  = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     3, 0, 0, 2'b00, 18'h14,     0};
    vecs[5]  = '{1, 0, 0, 0, 18'h20,     18'h0,      18'h0,     0, 0, 0, 2'b11, 18'h20,     0};
    vecs[6]  = '{1, 1, 1, 1, 18'h100,    18'h300,    18'h200,   0, 0, 0, 2'b11, 18'h100,    0};
    vecs[7]  = '{0, 1, 1, 1, 18'h0,      18'h300,    18'h20,    0, 0, 0, 2'b10, 18'h20,     0};
    vecs[8]  = '{0, 0, 1, 0, 18'h3,      18'h80,     18'h0,     0, 0, 0, 2'b00, 18'h24,     0};
    vecs[9]  = '{0, 0, 1, 1, 18'h0,      18'h80,     18'h1,     0, 0, 0, 2'b01, 18'h80,     0};
    vecs[10] = '{0, 0, 0, 1, 18'h0,      18'h200,    18'h0,     0, 0, 0, 2'b00, 18'h84,     0};
    vecs[11] = '{1, 0, 0, 0, 18'h3FFFC,  18'h0,      18'h0,     0, 0, 0, 2'b11, 18'h3FFFC,  0};
    vecs[12] = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     0, 0, 0, 2'b00, 18'h0,      0};
    vecs[13] = '{0, 1, 0, 0, 18'h0,      18'h0,      18'h42,    0, 0, 0, 2'b10, 18'h40,     1};
    vecs[14] = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     1, 0, 0, 2'b00, 18'h44,     1};
    vecs[15] = '{0, 0, 0, 0, 18'h0,      18'h0,      18'h0,     0, 2, 1, 2'b00, 18'h48,     1};

    clear_inputs();
    rst_n = 0;
    @(negedge clk);
    check("rst pc", 32'(pc), 0);
    check("rst imem_req", 32'(bus.imem_req), 0);
    check("rst halted", 32'(halted), 0);
    check("rst instr_valid", 32'(instr_valid), 0);
    check("rst jump_op", 32'(jump_op), 0);
    check("rst err", 32'(misalign_err), 0);
    rst_n = 1;
    #1;
    check("boot imem_req", 32'(bus.imem_req), 0);
    @(negedge clk);
    cur_pc = '0;

    for (int i = 0; i < 16; i++) do_instr(vecs[i], i);

    // Halted: no more requests, PC frozen, imem_ready ignored
    for (int i = 0; i < 3; i++) begin
      bus.imem_ready = 1;
      @(negedge clk);
      check("halt req", 32'(bus.imem_req), 0);
      check("halt pc", 32'(pc), 32'h48);
      check("halt halted", 32'(halted), 1);
      check("halt valid", 32'(instr_valid), 0);
    end
    bus.imem_ready = 0;

    // Reset out of HALT clears sticky flags
    rst_n = 0;
    #1;
    check("rst2 pc", 32'(pc), 0);
    check("rst2 halted", 32'(halted), 0);
    check("rst2 err", 32'(misalign_err), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    cur_pc = '0;
    do_instr(vecs[0], 100);

    // Async reset in the middle of a FETCH cycle
    #2;
    rst_n = 0;
    #1;
    check("async pc", 32'(pc), 0);
    check("async req", 32'(bus.imem_req), 0);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    while (bus.imem_req !== 1'b1 && n < 5) begin
      @(negedge clk);
      n++;
    end
    check("restart req", 32'(bus.imem_req), 1);
    check("restart addr", 32'(bus.imem_addr), 0);
    check("restart latency", 32'(n), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
